// File: rtl/expr_emitter.sv
// expr_emitter: serialises buffered digit/operator tokens into an ASCII expression stream
module expr_emitter #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tok_valid,
  output logic       tok_ready,
  input  logic [3:0] tok_digit,
  input  logic       tok_op,
  input  logic       tok_last,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       done,
  output logic [7:0] char_cnt,
  output logic       err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, DIG, OP} state_t;
  state_t      state = IDLE;
  logic [5:0]  mem [DEPTH] = '{default: '0};
  logic [AW-1:0] wr_ptr = '0;
  logic [AW-1:0] rd_ptr = '0;
  logic [AW:0] count = '0;
  logic        op_l = 1'b0;
  logic        ready_r = 1'b1;
  logic [7:0]  out_r = 8'h00;
  logic        valid_r = 1'b0;
  logic        done_r = 1'b0;
  logic [7:0]  cnt_r = 8'h00;
  logic        err_r = 1'b0;
  logic        hs, push, pop;
  logic [5:0]  head;
  logic [AW:0] count_next;
  logic [7:0]  cnt_inc;
  assign hs = tok_valid && ready_r;
  assign push = hs && tok_digit <= 4'd9;
  assign pop = state != OP && count != '0;
  assign head = mem[rd_ptr];
  assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign cnt_inc = cnt_r + {7'd0, cnt_r != 8'hFF};
  assign tok_ready = ready_r;
  assign out = out_r;
  assign out_valid = valid_r;
  assign done = done_r;
  assign char_cnt = cnt_r;
  assign err = err_r;
  // token storage; head slot is never read in the same edge it is written
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {tok_digit, tok_op, tok_last};
  // FIFO pointers, occupancy, registered ready and sticky illegal-digit flag
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ready_r <= 1'b1;
      err_r <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      ready_r <= count_next < FULL;
      if (hs && tok_digit > 4'd9) err_r <= 1'b1;
    end
  // emitter FSM: digit from the FIFO head, then the latched operator
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= IDLE;
      out_r <= 8'h00;
      valid_r <= 1'b0;
      done_r <= 1'b0;
      cnt_r <= 8'h00;
      op_l <= 1'b0;
    end else if (pop) begin
      out_r <= 8'h30 + {4'h0, head[5:2]};
      valid_r <= 1'b1;
      done_r <= head[0];
      op_l <= head[1];
      cnt_r <= state == IDLE ? 8'd1 : cnt_inc;
      state <= head[0] ? IDLE : OP;
    end else if (state == OP) begin
      out_r <= op_l ? 8'h2A : 8'h2B;
      valid_r <= 1'b1;
      done_r <= 1'b0;
      cnt_r <= cnt_inc;
      state <= DIG;
    end else begin
      out_r <= 8'h00;
      valid_r <= 1'b0;
      done_r <= 1'b0;
    end
endmodule

// File: tb/tb_expr_emitter.sv
// tb_expr_emitter: random and directed token streams checked against a character-stream model
module tb_expr_emitter;
  localparam int DEPTH = 4;
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       tok_valid = 1'b0;
  logic       tok_ready;
  logic [3:0] tok_digit = 4'd0;
  logic       tok_op = 1'b0;
  logic       tok_last = 1'b0;
  logic [7:0] out;
  logic       out_valid;
  logic       done;
  logic [7:0] char_cnt;
  logic       err;
  typedef struct {
    logic [7:0] c;
    bit         fin;
    bit         dig;
    int         w;
  } ch_t;
  ch_t  q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  int   buffered = 0;
  bit   err_exp = 0;
  bit   first = 1;
  int   cnt_exp = 0;
  expr_emitter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_digit(tok_digit), .tok_op(tok_op), .tok_last(tok_last),
    .out(out), .out_valid(out_valid), .done(done), .char_cnt(char_cnt), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask
  // accepted tokens become expected characters, stamped with their write edge
  always @(posedge clk) begin
    edge_n++;
    if (!clr && tok_valid && tok_ready) begin
      if (tok_digit > 9) err_exp = 1;
      else begin
        q.push_back('{8'h30 + 8'(tok_digit), tok_last, 1'b1, edge_n});
        if (!tok_last) q.push_back('{tok_op ? 8'h2A : 8'h2B, 1'b0, 1'b0, edge_n});
        buffered++;
      end
    end
  end
  // outputs are compared mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (clr) begin
      check("rst_out", out, 8'h00);
      check("rst_valid", out_valid, 0);
      check("rst_done", done, 0);
      check("rst_cnt", char_cnt, 0);
      check("rst_err", err, 0);
      check("rst_ready", tok_ready, 1);
      q.delete();
      buffered = 0;
      err_exp = 0;
      first = 1;
      cnt_exp = 0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) check("spurious_char", out, 0);
        else begin
          ch_t h;
          h = q.pop_front();
          check("char", out, h.c);
          check("done", done, h.fin);
          check("no_bypass", h.w < edge_n, 1);
          cnt_exp = first ? 1 : (cnt_exp < 255 ? cnt_exp + 1 : 255);
          first = h.fin;
          if (h.dig) buffered--;
        end
      end else begin
        check("idle_out", out, 8'h00);
        check("idle_done", done, 0);
        if (q.size() != 0) check("stall_latency", q[0].w, edge_n);
      end
      check("char_cnt", char_cnt, cnt_exp);
      check("err", err, err_exp);
      check("tok_ready", tok_ready, buffered < DEPTH);
    end
  end
  task automatic send(input int d, input int o, input int l);
    bit ok;
    int n;
    tok_valid = 1;
    tok_digit = d[3:0];
    tok_op = o[0];
    tok_last = l[0];
    n = 0;
    do begin
      ok = tok_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 100);
    if (!ok) check("send_timeout", 0, 1);
    tok_valid = 0;
  endtask
  task automatic idle(input int n);
    tok_valid = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse_clr();
    clr = 1;
    @(posedge clk);
    #1;
    clr = 0;
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    clr = 0;
    idle(2);
    send(3, 0, 0); send(5, 1, 0); send(7, 0, 1);
    idle(8);
    send(9, 1, 1);
    idle(4);
    for (int i = 0; i < 10; i++) send(i, i % 2, i == 9);
    idle(30);
    send(2, 0, 0); idle(3); send(4, 1, 1);
    idle(6);
    send(1, 0, 0); send(12, 0, 0); send(6, 0, 1);
    idle(6);
    send(5, 0, 0); send(6, 1, 1);
    n = 0;
    while (!(out_valid && out == 8'h2B) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("plus_timeout", 0, 1);
    pulse_clr();
    idle(2);
    send(8, 0, 1);
    idle(5);
    for (int i = 0; i < 130; i++) send(i % 10, i % 3 == 0, i == 129);
    idle(10);
    for (int i = 0; i < 300; i++) begin
      send($urandom_range(0, 11), $urandom_range(0, 1), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    send(0, 0, 1);
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    idle(3);
    check("drain", q.size(), 0);
    pulse_clr();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/expr_emitter.md
EXPR_EMITTER -- requirements
Module: expr_emitter

Purpose: serialise buffered operand/operator tokens into an ASCII expression stream of the form digit (op digit)*, one character per cycle. This is the transmit side of the team's expression-string checker.

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, token FIFO depth (power of two, >=2).
REQ-002 SHALL provide port clk  input  1  rising-edge clock.
REQ-003 SHALL provide port clr  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port tok_valid  input  1  token offered this cycle.
REQ-005 SHALL provide port tok_ready  output  1  FIFO can accept a token this cycle.
REQ-006 SHALL provide port tok_digit  input  4  operand value, legal range 0-9.
REQ-007 SHALL provide port tok_op  input  1  operator following the operand: 0 = "+", 1 = "*".
REQ-008 SHALL provide port tok_last  input  1  final operand of the expression; tok_op ignored.
REQ-009 SHALL provide port out  output  8  emitted ASCII character.
REQ-010 SHALL provide port out_valid  output  1  out carries a character this cycle.
REQ-011 SHALL provide port done  output  1  one-cycle pulse coincident with the final digit.
REQ-012 SHALL provide port char_cnt  output  8  characters emitted in the current expression.
REQ-013 SHALL provide port err  output  1  sticky flag: an illegal digit was offered.

Function
REQ-014 SHALL register every output, updating them only on a clk rising edge or on clr.
REQ-015 SHALL complete a token handshake on an edge where tok_valid && tok_ready are both high.
REQ-016 SHALL drive tok_ready = (FIFO count < DEPTH), using the count before the edge; a same-cycle pop SHALL NOT admit a push into a full FIFO.
REQ-017 SHALL accept but discard a handshaked token with tok_digit > 9: no FIFO write, err set to 1.
REQ-018 SHALL store each legal token {digit, op, last} in FIFO order, with pointers wrapping modulo DEPTH.
REQ-019 SHALL implement FSM states IDLE (no expression active), DIG (next character is a digit) and OP (next character is an operator).
REQ-020 SHALL, in IDLE or DIG with the FIFO non-empty, pop the head token on that edge and set out = 8'h30 + digit, out_valid = 1.
REQ-021 SHALL, on the pop in REQ-020, latch the head token's op and go to OP if last = 0.
REQ-022 SHALL, on the pop in REQ-020, set done = 1 and go to IDLE if last = 1.
REQ-023 SHALL, in OP, set out = "+" (8'h2B) or "*" (8'h2A) from the latched op, out_valid = 1, then go to DIG.
REQ-024 SHALL, in DIG with the FIFO empty, stay in DIG with out_valid = 0 and out = 8'h00.
REQ-025 SHALL, in IDLE with the FIFO empty, drive out_valid = 0 and out = 8'h00.
REQ-026 SHALL, with no FIFO write in between, drive out_valid = 0, out = 8'h00 and done = 0 on the edge after a done pulse.
REQ-027 SHALL NOT pop a FIFO token in OP.
REQ-028 SHALL make a token written at edge k visible as a digit at edge k+1 at the earliest; no write-to-pop bypass in the same edge.
REQ-029 SHALL load char_cnt with 1 on a digit emitted from IDLE.
REQ-030 SHALL otherwise increment char_cnt per emitted character, saturating at 255.
REQ-031 SHALL hold char_cnt after done until the next expression starts.
REQ-032 SHALL give priority to the token-side discard for err; err SHALL clear only on clr.
REQ-033 SHALL push and pop simultaneously when the FIFO is not full; count unchanged.

Reset
REQ-034 SHALL, while clr = 1, hold state = IDLE and FIFO count/pointers = 0.
REQ-035 SHALL, while clr = 1, hold out = 8'h00, out_valid = 0, done = 0, char_cnt = 0, err = 0 and tok_ready = 1.
REQ-036 SHALL abort any expression in progress on clr, with no further characters from the aborted expression.
REQ-037 SHALL also initialise every register to its reset value at time zero.

Verification
REQ-038 SHALL cover: tokens (3,+,0),(5,*,0),(7,-,1) on consecutive cycles -> out "3","+","5","*","7" on 5 consecutive cycles, done with "7", char_cnt = 5.
REQ-039 SHALL cover: single token (9,-,1) from IDLE -> one cycle out = 8'h39, done = 1, char_cnt = 1, then out_valid = 0.
REQ-040 SHALL cover: tok_valid held high for 10 tokens, DEPTH = 4 -> tok_ready drops once 4 are buffered, no token lost or reordered, output strictly alternates digit/op.
REQ-041 SHALL cover: (2,+,0), 3 idle cycles, (4,-,1) -> "2","+", then out_valid = 0 with out = 8'h00 until "4" follows 1 cycle after its write; done with "4", char_cnt = 3.
REQ-042 SHALL cover: token digit 12 amid (1,+,0),(6,-,1) -> err = 1 and held, stream "1","+","6" unaffected.
REQ-043 SHALL cover: clr pulsed right after "+" -> next outputs all zero, tok_ready = 1; a new (8,-,1) then yields "8", done, char_cnt = 1.
